// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment display: segment patterns
// ({a,b,c,d,e,f,g,dp}, active-high), digit positions and the frame snapshot type.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_DASH  = 8'h02;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_D     = 8'h7A;
  localparam logic [7:0] SEG_N     = 8'h2A;

  // Digit positions; bit 7 of seg_com is the leftmost digit.
  localparam logic [IDX_W-1:0] DIG_HT = 3'd7;
  localparam logic [IDX_W-1:0] DIG_HO = 3'd6;
  localparam logic [IDX_W-1:0] DIG_MT = 3'd5;
  localparam logic [IDX_W-1:0] DIG_MO = 3'd4;
  localparam logic [IDX_W-1:0] DIG_ST = 3'd3;
  localparam logic [IDX_W-1:0] DIG_SO = 3'd2;
  localparam logic [IDX_W-1:0] DIG_SP = 3'd1;
  localparam logic [IDX_W-1:0] DIG_DN = 3'd0;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       d_or_n;
  } snap_t;

  localparam snap_t SNAP_RESET = '{hour: 8'h00, min: 8'h00, sec: 8'h00, d_or_n: 1'b1};

endpackage

// File: rtl/seg_scan_display_bcd_to_seg.sv
// Combinational BCD nibble to a..g segment pattern; nibbles A..F show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_seg = SEG_DASH[7:1];
    case (i_bcd)
      4'd0:    o_seg = SEG_0[7:1];
      4'd1:    o_seg = SEG_1[7:1];
      4'd2:    o_seg = SEG_2[7:1];
      4'd3:    o_seg = SEG_3[7:1];
      4'd4:    o_seg = SEG_4[7:1];
      4'd5:    o_seg = SEG_5[7:1];
      4'd6:    o_seg = SEG_6[7:1];
      4'd7:    o_seg = SEG_7[7:1];
      4'd8:    o_seg = SEG_8[7:1];
      4'd9:    o_seg = SEG_9[7:1];
      default: o_seg = SEG_DASH[7:1];
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// 8-digit multiplexed display of HH MM SS, blank, day/night letter with a per-frame input snapshot.
// Optional: define LEADING_ZERO_BLANK_EN to blank the leftmost digit when the hour tens is 0.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 1
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic       d_or_n,
  output logic [7:0] seg_data,
  output logic [7:0] seg_com
);

  localparam int               DIV_W    = ($clog2(SCAN_DIV + 1) < 1) ? 1 : $clog2(SCAN_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [IDX_W-1:0] r_idx;
  snap_t            r_snap;
  logic             w_tick;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg7;
  logic [7:0]       w_digit;

  assign w_tick = (r_div == DIV_LAST);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
      r_idx <= DIG_HT;
    end else if (w_tick) begin
      r_div <= '0;
      r_idx <= r_idx - IDX_W'(1);
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Loaded only on the wrap back to the leftmost digit, so a frame never mixes two times.
  // NOTE: the snapshot is reset because the first frame must show a defined "000000 n" image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap <= SNAP_RESET;
    end else if (w_tick && (r_idx == DIG_DN)) begin
      r_snap <= '{hour: hour, min: min, sec: sec, d_or_n: d_or_n};
    end
  end

  always_comb begin
    w_nibble = r_snap.hour[7:4];
    case (r_idx)
      DIG_HO:  w_nibble = r_snap.hour[3:0];
      DIG_MT:  w_nibble = r_snap.min[7:4];
      DIG_MO:  w_nibble = r_snap.min[3:0];
      DIG_ST:  w_nibble = r_snap.sec[7:4];
      DIG_SO:  w_nibble = r_snap.sec[3:0];
      default: w_nibble = r_snap.hour[7:4];
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .i_bcd (w_nibble),
    .o_seg (w_seg7)
  );

  // Colon dots after the hour and minute digits blink on even seconds.
  always_comb begin
    w_digit = {w_seg7, 1'b0};
    case (r_idx)
      DIG_SP:         w_digit = SEG_BLANK;
      DIG_DN:         w_digit = r_snap.d_or_n ? SEG_N : SEG_D;
      DIG_HO, DIG_MO: w_digit[0] = ~r_snap.sec[0];
`ifdef LEADING_ZERO_BLANK_EN
      DIG_HT:         if (r_snap.hour[7:4] == 4'd0) w_digit = SEG_BLANK;
`endif
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_com  <= 8'hFF;
      seg_data <= SEG_BLANK;
    end else begin
      seg_com  <= ~(8'b1 << r_idx);
      seg_data <= w_digit;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: two instances (SCAN_DIV=1 and 3), randomized
// time values with decoy mid-frame changes, expected frames built from the display rules.
`timescale 1ns/1ps
module tb_seg_scan_display;

  typedef struct packed {
    logic [7:0] com;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic [7:0] hour = 8'h00;
  logic [7:0] min = 8'h00;
  logic [7:0] sec = 8'h00;
  logic       d_or_n = 1'b1;
  logic [7:0] com_a, data_a, com_b, data_b;

  int checks = 0;
  int failures = 0;

  exp_t       q_a[$];
  exp_t       q_b[$];
  int         run[2];
  logic [7:0] prev[2];
  exp_t       cur[2];

  always #5 clk = ~clk;

  seg_scan_display #(.SCAN_DIV(1)) dut_a (
    .clk(clk), .rst(rst_a), .hour(hour), .min(min), .sec(sec), .d_or_n(d_or_n),
    .seg_data(data_a), .seg_com(com_a)
  );

  seg_scan_display #(.SCAN_DIV(3)) dut_b (
    .clk(clk), .rst(rst_b), .hour(hour), .min(min), .sec(sec), .d_or_n(d_or_n),
    .seg_data(data_b), .seg_com(com_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dec(input logic [3:0] n);
    case (n)
      4'd0: return 8'hFC;
      4'd1: return 8'h60;
      4'd2: return 8'hDA;
      4'd3: return 8'hF2;
      4'd4: return 8'h66;
      4'd5: return 8'hB6;
      4'd6: return 8'hBE;
      4'd7: return 8'hE0;
      4'd8: return 8'hFE;
      4'd9: return 8'hF6;
      default: return 8'h02;
    endcase
  endfunction

  function automatic void sb_push(input int id, input exp_t e);
    if (id == 0) q_a.push_back(e);
    else         q_b.push_back(e);
  endfunction

  function automatic exp_t sb_pop(input int id);
    exp_t e;
    if (id == 0) e = q_a.pop_front();
    else         e = q_b.pop_front();
    return e;
  endfunction

  function automatic int sb_size(input int id);
    return (id == 0) ? q_a.size() : q_b.size();
  endfunction

  // One frame, left to right, as the viewer should see it for a given snapshot.
  function automatic void push_frame(input int id, input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s, input logic dn);
    logic [7:0] f[3];
    logic [3:0] nib;
    exp_t       e;
    f[0] = h; f[1] = m; f[2] = s;
    for (int j = 0; j < 8; j++) begin
      e.com = 8'hFF;
      e.com[7-j] = 1'b0;
      if (j < 6) begin
        nib = (j % 2 == 0) ? f[j/2][7:4] : f[j/2][3:0];
        e.data = dec(nib);
        if ((j == 1 || j == 3) && !s[0]) e.data[0] = 1'b1;
      end else if (j == 6) begin
        e.data = 8'h00;
      end else begin
        e.data = dn ? 8'h2A : 8'h7A;
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (j == 0 && h[7:4] == 4'd0) e.data = 8'h00;
`endif
      sb_push(id, e);
    end
  endfunction

  task automatic mon_step(input int id, input logic r, input logic [7:0] com,
                          input logic [7:0] data, input int d);
    if (!r) begin
      prev[id] = 8'hFF;
      run[id]  = 0;
    end else if (com != prev[id]) begin
      if (prev[id] != 8'hFF) check($sformatf("d%0d_hold_cycles", id), run[id], d);
      check($sformatf("d%0d_sb_nonempty", id), (sb_size(id) != 0), 1);
      if (sb_size(id) != 0) begin
        cur[id] = sb_pop(id);
        check($sformatf("d%0d_seg_com", id), com, cur[id].com);
        check($sformatf("d%0d_seg_data", id), data, cur[id].data);
      end
      prev[id] = com;
      run[id]  = 1;
    end else begin
      run[id]++;
      if (prev[id] != 8'hFF) check($sformatf("d%0d_seg_data_hold", id), data, cur[id].data);
    end
  endtask

  always @(negedge clk) mon_step(0, rst_a, com_a, data_a, 1);
  always @(negedge clk) mon_step(1, rst_b, com_b, data_b, 3);

  task automatic set_rst(input int id, input logic v);
    if (id == 0) rst_a = v;
    else         rst_b = v;
  endtask

  function automatic logic [7:0] get_com(input int id);
    return (id == 0) ? com_a : com_b;
  endfunction

  function automatic logic [7:0] get_data(input int id);
    return (id == 0) ? data_a : data_b;
  endfunction

  task automatic set_inputs(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            input logic dn);
    hour = h; min = m; sec = s; d_or_n = dn;
  endtask

  // Spans one displayed frame; a decoy change and then the real next-frame values both
  // land mid-frame and must stay invisible until the wrap.
  task automatic run_frame(input int id, input int d, input bit rnd, input logic [7:0] h,
                           input logic [7:0] m, input logic [7:0] s, input logic dn);
    int         fl, c1, c2;
    logic [7:0] th, tm, ts;
    logic       tdn;
    fl = 8 * d;
    c1 = $urandom_range(0, fl - 3);
    c2 = $urandom_range(c1 + 1, fl - 2);
    th = h; tm = m; ts = s; tdn = dn;
    if (rnd) begin
      th = 8'($urandom); tm = 8'($urandom); ts = 8'($urandom); tdn = 1'($urandom);
    end
    for (int c = 0; c < fl; c++) begin
      @(negedge clk);
      if (c == c1) set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      if (c == c2) set_inputs(th, tm, ts, tdn);
    end
    push_frame(id, th, tm, ts, tdn);
  endtask

  task automatic phase(input int id, input int d);
    set_rst(id, 1'b0);
    repeat (3) @(negedge clk);
    check($sformatf("d%0d_reset_com", id), get_com(id), 8'hFF);
    check($sformatf("d%0d_reset_data", id), get_data(id), 8'h00);
    push_frame(id, 8'h00, 8'h00, 8'h00, 1'b1);
    #1 set_rst(id, 1'b1);
    run_frame(id, d, 1'b0, 8'h23, 8'h59, 8'h07, 1'b0);
    run_frame(id, d, 1'b0, 8'h12, 8'h34, 8'h56, 1'b1);
    run_frame(id, d, 1'b0, 8'h13, 8'h34, 8'h56, 1'b1);
    run_frame(id, d, 1'b0, 8'h09, 8'hA5, 8'h10, 1'b0);
    run_frame(id, d, 1'b0, 8'h20, 8'h00, 8'h59, 1'b1);
    repeat (6) run_frame(id, d, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);

    // Asynchronous reset while the seconds-tens digit is lit.
    repeat (4 * d + 1) @(negedge clk);
    check($sformatf("d%0d_pre_reset_com", id), get_com(id), 8'hF7);
    #2 set_rst(id, 1'b0);
    #1;
    check($sformatf("d%0d_async_reset_com", id), get_com(id), 8'hFF);
    check($sformatf("d%0d_async_reset_data", id), get_data(id), 8'h00);
    if (id == 0) q_a.delete();
    else         q_b.delete();
    repeat (2) @(negedge clk);
    push_frame(id, 8'h00, 8'h00, 8'h00, 1'b1);
    #1 set_rst(id, 1'b1);
    repeat (3) run_frame(id, d, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);

    repeat (8 * d) @(negedge clk);
    #2 set_rst(id, 1'b0);
    check($sformatf("d%0d_sb_drained", id), sb_size(id), 0);
  endtask

  initial begin
    phase(0, 1);
    phase(1, 3);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Downstream consumer of the real-time clock block's BCD time and day/night flag. Drives an 8-digit common-cathode multiplexed seven-segment display on the training board: HH MM SS, one blank digit, then a day/night letter. A scan divider walks the digits one at a time. Inputs are snapshotted once per frame so a carry that ripples mid-frame cannot tear the displayed value.

Parameters:
SCAN_DIV, 1, clk cycles each digit stays selected; legal range 1..255; counter width is $clog2(SCAN_DIV+1), minimum 1 bit.

Ports:
clk  in  1  system clock (board 1 kHz tick clock)
rst  in  1  reset
hour  in  8  BCD hour, [7:4] tens, [3:0] ones
min  in  8  BCD minute
sec  in  8  BCD second
d_or_n  in  1  0 = day, 1 = night
seg_data  out  8  segment pattern {a,b,c,d,e,f,g,dp}; active-high; registered
seg_com  out  8  digit select, active-low one-hot; bit 7 is the leftmost digit; registered

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk.
  - Reset values: div=0, idx=7, snapshot hour/min/sec=8'h00, snapshot d_or_n=1, seg_com=8'hFF (all off), seg_data=8'h00.
- Divider: div counts 0..SCAN_DIV-1. tick = (div==SCAN_DIV-1); on tick div<=0. With SCAN_DIV=1, tick is asserted every cycle.
- Digit index: on tick, idx<=idx-1 and wraps 0->7. Scan order is 7,6,...,0.
- Snapshot: on the tick where idx==0 (wrap to 7), latch hour, min, sec and d_or_n. This is the only time the snapshot is loaded, so every frame shows a consistent set of values.
- Output stage, every clk:
  - seg_com <= ~(8'b1<<idx).
  - seg_data <= decode(digit[idx]) from the snapshot.
  - Latency from an idx change to the outputs is exactly 1 cycle.
  - The first frame after reset shows the reset snapshot, i.e. "000000" + blank + "n".
- Digit map:
  - idx7 = hour[7:4]
  - idx6 = hour[3:0]
  - idx5 = min[7:4]
  - idx4 = min[3:0]
  - idx3 = sec[7:4]
  - idx2 = sec[3:0]
  - idx1 = blank (8'h00)
  - idx0 = letter: 'd' 8'h7A when d_or_n=0, 'n' 8'h2A when d_or_n=1
- Decode (dp bit=0):
  - 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6
  - Nibble A..F is not valid BCD and shows '-' = 8'h02.
- Colon dots: dp (bit 0) is set on idx6 and idx4 when snapshot sec[0]==0 (even second), and cleared otherwise. dp is always 0 on all other digits.
- Input changes between snapshots have no effect on the outputs.
- Reset mid-frame: the outputs blank immediately (asynchronous). Scanning restarts at idx7 on the first clk after rst deasserts.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: when snapshot hour[7:4]==0, idx7 outputs 8'h00 (blank) instead of '0'. All other digits are unaffected.
- Undefined: idx7 always shows the decoded tens digit, including '0'.

Decomposition:
- Shared package seg_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK, SEG_D, SEG_N
  - digit index localparams DIG_HT, DIG_HO, DIG_MT, DIG_MO, DIG_ST, DIG_SO, DIG_SP, DIG_DN
  - NUM_DIGITS=8
- One sub-module, bcd_to_seg: combinational 4-bit nibble -> 7-bit a..g pattern, invalid nibbles -> dash. The top level adds dp and handles the blank and letter digits.

Test Plan:
1. SCAN_DIV=1, rst low 3 cycles then high, hour/min/sec held at 0, d_or_n=1.
   - During reset: seg_com=FF, seg_data=00.
   - After reset: seg_com cycles 7F,BF,DF,EF,F7,FB,FD,FE, one per cycle.
   - Digits 7..2 show FC; digit 6 and digit 4 show FD (dp set, sec even); digit 1 shows 00; digit 0 shows 2A.
2. SCAN_DIV=1, inputs hour=8'h23, min=8'h59, sec=8'h07, d_or_n=0, applied before a frame wrap.
   - Next frame: DA, F2 (dp=0 since sec odd), B6, F6, FC, E0, 00, 7A.
3. Snapshot hold: change hour 8'h12 -> 8'h13 while idx=4.
   - Rest of the current frame still uses 8'h12.
   - Digit 6 shows F2 ('3') only from the next frame.
4. SCAN_DIV=3: each seg_com value is held exactly 3 cycles.
   - Full frame = 24 cycles.
   - idx0 -> idx7 wrap and snapshot load both land on the same edge.
5. Invalid BCD: min=8'hA5.
   - Digit 5 shows 02; digit 4 shows B7 when sec is even.
   - Under LEADING_ZERO_BLANK_EN with hour=8'h09, digit 7 shows 00.
6. Assert rst while idx=3.
   - seg_com=FF and seg_data=00 immediately, without waiting for clk.
   - After release, the first selected digit is 7F with hour tens from the reset snapshot (FC).
